// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer: walks the tile map per scanline, fetches sprite rows from the sprite store,
// and maps each 2-bit pixel through an Avalon-writable palette bank to 12-bit RGB.
module sprite_line_renderer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int MAP_AW = 12
) (
  input  logic              CLK_100,
  input  logic              RESET,
  input  logic              AVL_READ,
  input  logic              AVL_WRITE,
  input  logic              AVL_CS,
  input  logic [5:0]        AVL_ADDR,
  input  logic [31:0]       AVL_WRITEDATA,
  output logic [31:0]       AVL_READDATA,
  input  logic              LINE_START,
  input  logic [8:0]        LINE_Y,
  input  logic              PIX_EN,
  output logic [MAP_AW-1:0] MAP_ADDR,
  input  logic [15:0]       MAP_DATA,
  output logic [7:0]        get_index,
  output logic [3:0]        get_line,
  input  logic [15:0]       get_data,
  output logic [11:0]       RGB,
  output logic              PIX_VALID,
  output logic              UNDERRUN
);
  localparam int CW = $clog2(COLS + 1);
  localparam logic [CW-1:0] COLS_W = CW'(COLS);
  localparam logic [8:0] Y_MAX = 9'(ROWS * 16);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MAP   = 3'd1;
  localparam logic [2:0] S_MWAIT = 3'd2;
  localparam logic [2:0] S_SPR   = 3'd3;
  localparam logic [2:0] S_SWAIT = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [4:0]        row_q;
  logic [3:0]        srow_q;
  logic [CW-1:0]     col_q, cons_q;
  logic [2:0]        pcnt_q, fpal_q, npal_q, spal_q;
  logic [15:0]       nbuf_q, shift_q;
  logic              nvalid_q;
  logic [11:0]       pal_q [32];
  logic [11:0]       rgb_q;
  logic              pv_q, unr_q;
  logic [31:0]       rd_q;
  logic [MAP_AW-1:0] maddr_q;
  logic [7:0]        gidx_q;
  logic [3:0]        gline_q;
  logic              pix_on, first, load, start, unr_set, unr_clr, wr, rd, oob;
  logic [1:0]        bits;
  logic [2:0]        psel;
  logic              unused;

  assign unused = ^{MAP_DATA[15:11], AVL_WRITEDATA[31:12]};

  always_comb begin
    pix_on  = PIX_EN && !LINE_START;
    first   = pcnt_q == 3'd0;
    load    = pix_on && first && nvalid_q;
    bits    = first ? (nvalid_q ? nbuf_q[15:14] : 2'b00) : shift_q[15:14];
    psel    = first ? (nvalid_q ? npal_q : 3'd0) : spal_q;
    unr_set = pix_on && first && !nvalid_q && cons_q < COLS_W;
    // a cell consumed this cycle frees the buffer, so the next fetch may start at once
    start   = !LINE_START && state_q == S_IDLE && (!nvalid_q || load) && col_q < COLS_W;
    wr      = AVL_CS && AVL_WRITE;
    rd      = AVL_CS && AVL_READ;
    unr_clr = wr && AVL_ADDR == 6'd32 && AVL_WRITEDATA[0];
    oob     = LINE_Y >= Y_MAX;
    state_d = LINE_START ? S_IDLE :
              state_q == S_IDLE ? (start ? S_MAP : S_IDLE) :
              state_q == S_SWAIT ? S_IDLE : state_q + 3'd1;
  end

  always_ff @(posedge CLK_100 or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      srow_q   <= '0;
      col_q    <= '0;
      cons_q   <= '0;
      pcnt_q   <= '0;
      fpal_q   <= '0;
      npal_q   <= '0;
      spal_q   <= '0;
      nbuf_q   <= '0;
      shift_q  <= '0;
      nvalid_q <= 1'b0;
      rgb_q    <= '0;
      pv_q     <= 1'b0;
      unr_q    <= 1'b0;
      rd_q     <= '0;
      maddr_q  <= '0;
      gidx_q   <= '0;
      gline_q  <= '0;
      for (int i = 0; i < 32; i++) pal_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (wr && !AVL_ADDR[5]) pal_q[AVL_ADDR[4:0]] <= AVL_WRITEDATA[11:0];
      if (rd) rd_q <= !AVL_ADDR[5] ? {20'd0, pal_q[AVL_ADDR[4:0]]} : {31'd0, AVL_ADDR == 6'd32 && unr_q};
      if (unr_clr) unr_q <= 1'b0;
      if (unr_set) unr_q <= 1'b1;
      if (start) maddr_q <= MAP_AW'(row_q * COLS + col_q);
      if (state_q == S_MWAIT) begin
        gidx_q  <= MAP_DATA[7:0];
        gline_q <= srow_q;
        fpal_q  <= MAP_DATA[10:8];
      end
      if (load) nvalid_q <= 1'b0;
      if (state_q == S_SWAIT) begin
        nbuf_q   <= get_data;
        npal_q   <= fpal_q;
        nvalid_q <= 1'b1;
        col_q    <= col_q + 1'b1;
      end
      pv_q <= pix_on;
      if (pix_on) begin
        rgb_q   <= pal_q[{psel, bits}];
        pcnt_q  <= pcnt_q + 3'd1;
        shift_q <= first ? (nvalid_q ? {nbuf_q[13:0], 2'b00} : 16'd0) : {shift_q[13:0], 2'b00};
        if (first) spal_q <= psel;
        if (pcnt_q == 3'd7 && cons_q < COLS_W) cons_q <= cons_q + 1'b1;
      end
      // out-of-range lines start already "complete": no fetches and no underrun
      if (LINE_START) begin
        row_q    <= LINE_Y[8:4];
        srow_q   <= LINE_Y[3:0];
        col_q    <= oob ? COLS_W : '0;
        cons_q   <= oob ? COLS_W : '0;
        pcnt_q   <= '0;
        nvalid_q <= 1'b0;
        shift_q  <= '0;
      end
    end
  end

  assign AVL_READDATA = rd_q;
  assign MAP_ADDR     = maddr_q;
  assign get_index    = gidx_q;
  assign get_line     = gline_q;
  assign RGB          = rgb_q;
  assign PIX_VALID    = pv_q;
  assign UNDERRUN     = unr_q;
endmodule
